// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage. Owns the PC, reads imem, buffers {instr,pc}
// in a 2-entry FIFO and hands the head to decode over valid/ready.
//
// Parameter:
//   RESET_PC       - PC value loaded on reset
//
// Ports:
//   clk, rst_n     - rising-edge clock, async active-low reset
//   fetch_en       - fetch permitted (FIFO still drains when low)
//   imem_addr      - word address pc[13:2] to instruction memory
//   imem_rdata     - combinational read data for imem_addr
//   redirect_valid - load redirect_pc and flush the buffer
//   redirect_pc    - redirect target byte address
//   out_valid      - head entry valid toward decode
//   out_ready      - decode accepts head
//   out_instr      - head instruction word
//   out_pc         - head byte PC
//   fetch_fault    - misaligned-redirect fault
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q [2];
  logic [31:0] epc_q [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] last_instr_q;
  logic [31:0] last_pc_q;
  logic        tail;
  logic        pop;
  logic        push;
  logic        halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;

  assign halted      = halted_q;
  assign fetch_fault = halted_q;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = |redirect_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = pc_q[13:2];
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~halted & ~redirect_valid &
                     ((count_q != 2'd2) | pop);

  // Slot after the head; when full this is the head slot, which a
  // simultaneous pop is vacating.
  assign tail = head_q ^ count_q[0];

  // When empty, keep showing whatever was last at the head.
  assign out_instr = out_valid ? instr_q[head_q] : last_instr_q;
  assign out_pc    = out_valid ? epc_q[head_q] : last_pc_q;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirect_valid) begin
      count_d = 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d = redirect_pc;
`else
      pc_d = redirect_pc & ~32'h3;
`endif
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_d = ~head_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_q       <= 1'b0;
      last_instr_q <= 32'd0;
      last_pc_q    <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= 32'd0;
        epc_q[i]   <= 32'd0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (out_valid) begin
        last_instr_q <= instr_q[head_q];
        last_pc_q    <= epc_q[head_q];
      end
      if (push) begin
        instr_q[tail] <= imem_rdata;
        epc_q[tail]   <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Expected PCs are queued as stimulus is applied and checked on each pop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [11:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        out_valid, out_valid2;
  logic [31:0] out_instr, out_instr2;
  logic [31:0] out_pc, out_pc2;
  logic        fetch_fault, fetch_fault2;

  logic [31:0] mem [4096];
  logic [31:0] sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata2 = mem[imem_addr2];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'h0000_3FFC)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid2),
    .out_ready      (out_ready),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2),
    .fetch_fault    (fetch_fault2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_pop", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, mem[e[13:2]]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_addr", {20'd0, imem_addr}, 32'd0);
    chk("rst_addr2", {20'd0, imem_addr2}, 32'h0FFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'hC0DE_0000 | i;
    end
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
    #1;

    // Streaming from reset, plus PC wrap on the second instance.
    do_reset();
    out_ready = 1'b1;
    chk("t1_first_bubble", {31'd0, out_valid}, 32'd0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    sb.push_back(32'hC);
    cyc();
    chk("wrap_pc0", out_pc2, 32'h3FFC);
    chk("wrap_addr", {20'd0, imem_addr2}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      cyc();
      if (i == 0) begin
        chk("wrap_pc1", out_pc2, 32'h4000);
        chk("wrap_instr", out_instr2, 32'h11);
      end
    end
    out_ready = 1'b0;

    // Backpressure: FIFO fills, PC holds at 8.
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    chk("t2_addr", {20'd0, imem_addr}, 32'd2);
    chk("t2_head", out_pc, 32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      cyc();
    end
    out_ready = 1'b0;

    // Redirect while full.
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    redirect(32'h100);
    out_ready = 1'b1;
    chk("t3_bubble", {31'd0, out_valid}, 32'd0);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    cyc();
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    cyc();
    out_ready = 1'b0;

    // fetch_en low drains the buffer and freezes the PC.
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    cyc();
    cyc();
    chk("t4_empty", {31'd0, out_valid}, 32'd0);
    chk("t4_addr", {20'd0, imem_addr}, 32'd2);
    cyc();
    chk("t4_empty2", {31'd0, out_valid}, 32'd0);
    chk("t4_addr2", {20'd0, imem_addr}, 32'd2);
    fetch_en  = 1'b1;
    out_ready = 1'b0;

    // Misaligned redirect, then aligned redirect.
    do_reset();
    cyc();
    redirect(32'h102);
    chk("t5_bubble", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("t5_halt_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_fault_hold", {31'd0, fetch_fault}, 32'd1);
`else
    chk("t5_fault", {31'd0, fetch_fault}, 32'd0);
    out_ready = 1'b1;
    sb.push_back(32'h100);
    cyc();
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    cyc();
`endif
    out_ready = 1'b0;
    redirect(32'h200);
    chk("t5_fault_clr", {31'd0, fetch_fault}, 32'd0);
    chk("t5_bubble2", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    sb.push_back(32'h200);
    cyc();
    cyc();
    out_ready = 1'b0;
    chk("t5_fault_end", {31'd0, fetch_fault}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
